// File: rtl/fx_requant_pipe_if.sv
// Valid/ready stream bundle for the requantizer: wide signed input side and narrow output side.
// The slave modport is the requantizer's view; master is the surrounding logic.
interface fx_requant_pipe_if #(
  parameter int IN_W  = 15,
  parameter int OUT_W = 10
);
  logic [IN_W-1:0]  i_data;
  logic             i_valid;
  logic             i_ready;
  logic [OUT_W-1:0] o_data;
  logic             o_valid;
  logic             o_ready;

  modport master (
    output i_data, i_valid, o_ready,
    input  i_ready, o_data, o_valid
  );

  modport slave (
    input  i_data, i_valid, o_ready,
    output i_ready, o_data, o_valid
  );
endinterface

// File: rtl/fx_requant_pipe.sv
// Two-stage fixed-point requantizer: stage 1 drops LSBs with selectable rounding,
// stage 2 wraps or saturates into OUT_W bits and feeds a sticky flag / saturating overflow counter.
module fx_requant_pipe #(
  parameter int IN_W       = 15,
  parameter int IN_FRAC    = 10,
  parameter int OUT_W      = 10,
  parameter int OUT_FRAC   = 6,
  parameter int ROUND_MODE = 1,
  parameter int OVF_MODE   = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  fx_requant_pipe_if.slave bus,
  input  logic             i_clr_ovf,
  output logic             o_ovf_sticky,
  output logic [CNT_W-1:0] o_ovf_cnt
);

  localparam int D  = IN_FRAC - OUT_FRAC;
  localparam int QW = IN_W + 1;

  localparam logic signed [QW-1:0] Q_ZERO = '0;
  localparam logic signed [QW-1:0] Q_MAX  = QW'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [QW-1:0] Q_MIN  = ~Q_MAX;
  localparam logic [CNT_W-1:0]     CNT_MAX = '1;

  if (D < 0) begin : g_bad_frac
    $error("fx_requant_pipe: IN_FRAC must not be smaller than OUT_FRAC");
  end

  logic                    s1_v_q, s1_v_d;
  logic signed [QW-1:0]    s1_data_q, s1_data_d;
  logic                    s2_v_q, s2_v_d;
  logic [OUT_W-1:0]        s2_data_q, s2_data_d;
  logic                    sticky_q, sticky_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic                    adv1, adv2;
  logic signed [QW-1:0]    in_ext;
  logic signed [QW-1:0]    q_rnd;
  logic                    s2_ovf;
  logic [OUT_W-1:0]        s2_res;
  logic                    ovf_evt;

  // One extra headroom bit so rounding the most positive input up cannot wrap negative.
  assign in_ext = {bus.i_data[IN_W-1], bus.i_data};

  if (D == 0) begin : g_no_drop
    assign q_rnd = in_ext;
  end else begin : g_drop
    localparam logic signed [QW-1:0] HALF = QW'(2 ** (D - 1));

    logic                 tie;
    logic                 inc;
    logic signed [QW-1:0] addend;
    logic signed [QW-1:0] sum;

    always_comb begin
      tie = (bus.i_data[D-1:0] == HALF[D-1:0]);
      inc = 1'b1;
      case (ROUND_MODE)
        0:       inc = 1'b0;
        2:       inc = ~(tie & ~bus.i_data[D]);
        default: inc = 1'b1;
      endcase
      addend = inc ? HALF : Q_ZERO;
      sum    = in_ext + addend;
    end

    assign q_rnd = sum >>> D;
  end

  always_comb begin
    s2_ovf = (s1_data_q > Q_MAX) || (s1_data_q < Q_MIN);
    s2_res = s1_data_q[OUT_W-1:0];
    if ((OVF_MODE == 1) && s2_ovf) begin
      s2_res = s1_data_q[QW-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

  // Overflow is judged once, on the edge a sample moves into stage 2, so a held sample never recounts.
  always_comb begin
    adv2 = ~s2_v_q | bus.o_ready;
    adv1 = ~s1_v_q | adv2;

    s1_v_d    = adv1 ? bus.i_valid : s1_v_q;
    s1_data_d = (adv1 && bus.i_valid) ? q_rnd : s1_data_q;
    s2_v_d    = adv2 ? s1_v_q : s2_v_q;
    s2_data_d = (adv2 && s1_v_q) ? s2_res : s2_data_q;

    ovf_evt  = adv2 & s1_v_q & s2_ovf;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (i_clr_ovf) begin
      sticky_d = ovf_evt;
      cnt_d    = ovf_evt ? CNT_W'(1) : '0;
    end else if (ovf_evt) begin
      sticky_d = 1'b1;
      cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q    <= 1'b0;
      s1_data_q <= '0;
      s2_v_q    <= 1'b0;
      s2_data_q <= '0;
      sticky_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_data_q <= s1_data_d;
      s2_v_q    <= s2_v_d;
      s2_data_q <= s2_data_d;
      sticky_q  <= sticky_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.i_ready  = adv1;
  assign bus.o_valid  = s2_v_q;
  assign bus.o_data   = s2_data_q;
  assign o_ovf_sticky = sticky_q;
  assign o_ovf_cnt    = cnt_q;

endmodule

// File: tb/tb_fx_requant_pipe.sv
// Drives three requantizer configurations from one shared stream and scores them against an
// integer-arithmetic model of rounding, wrap/saturate and overflow counting.
module tb_fx_requant_pipe;

  localparam int SCALE = 16;
  localparam int RM   [3] = '{1, 2, 0};
  localparam int OM   [3] = '{1, 1, 0};
  localparam int CMAX [3] = '{65535, 3, 65535};

  logic        clk = 1'b0;
  logic        rst;
  logic [14:0] i_data;
  logic        i_valid;
  logic        o_ready;
  logic        clr;

  logic        sticky_a, sticky_b, sticky_c;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;
  logic [15:0] cnt_c;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit strict_lat = 1'b0;

  int exp_x[$];
  int exp_cyc[$];
  int log_a[$];
  int log_b[$];
  int log_c[$];
  int cnt_m[3];
  int sticky_m[3];

  bit          prev_stall = 1'b0;
  logic [9:0]  prev_data;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fx_requant_pipe_if #(.IN_W(15), .OUT_W(10)) bus_a ();
  fx_requant_pipe_if #(.IN_W(15), .OUT_W(10)) bus_b ();
  fx_requant_pipe_if #(.IN_W(15), .OUT_W(10)) bus_c ();

  assign bus_a.i_data = i_data;  assign bus_a.i_valid = i_valid;  assign bus_a.o_ready = o_ready;
  assign bus_b.i_data = i_data;  assign bus_b.i_valid = i_valid;  assign bus_b.o_ready = o_ready;
  assign bus_c.i_data = i_data;  assign bus_c.i_valid = i_valid;  assign bus_c.o_ready = o_ready;

  fx_requant_pipe #(.ROUND_MODE(1), .OVF_MODE(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .i_clr_ovf(clr), .o_ovf_sticky(sticky_a), .o_ovf_cnt(cnt_a)
  );
  fx_requant_pipe #(.ROUND_MODE(2), .OVF_MODE(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .i_clr_ovf(clr), .o_ovf_sticky(sticky_b), .o_ovf_cnt(cnt_b)
  );
  fx_requant_pipe #(.ROUND_MODE(0), .OVF_MODE(0), .CNT_W(16)) dut_c (
    .clk(clk), .rst(rst), .bus(bus_c), .i_clr_ovf(clr), .o_ovf_sticky(sticky_c), .o_ovf_cnt(cnt_c)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // Value the sample x/16 takes once rounded to an integer and fitted into 10 signed bits.
  function automatic int refQuant(input int x, input int rm, input int om, output bit ovf);
    int r, fl, q;
    r  = ((x % SCALE) + SCALE) % SCALE;
    fl = (x - r) / SCALE;
    case (rm)
      0:       q = fl;
      1:       q = fl + ((r >= SCALE / 2) ? 1 : 0);
      default: q = fl + (((r > SCALE / 2) || ((r == SCALE / 2) && (fl % 2 != 0))) ? 1 : 0);
    endcase
    ovf = (q > 511) || (q < -512);
    if (om == 1) begin
      if (q > 511)  q = 511;
      if (q < -512) q = -512;
    end
    return q & 1023;
  endfunction

  function automatic int logAt(input int u, input int idx);
    case (u)
      0:       return (idx < log_a.size()) ? log_a[idx] : -1;
      1:       return (idx < log_b.size()) ? log_b[idx] : -1;
      default: return (idx < log_c.size()) ? log_c[idx] : -1;
    endcase
  endfunction

  // Scoreboard: evaluates the handshakes that the coming rising edge will perform.
  always @(negedge clk) begin
    int x, e, lat;
    bit ovf;
    if (rst) begin
      exp_x.delete();
      exp_cyc.delete();
      for (int u = 0; u < 3; u++) begin
        cnt_m[u]    = 0;
        sticky_m[u] = 0;
      end
      prev_stall = 1'b0;
    end else begin
      checkOutput("i_ready", 32'(bus_a.i_ready), 32'(!(exp_x.size() == 2 && !o_ready)));
      if (prev_stall) begin
        checkOutput("hold_valid", 32'(bus_a.o_valid), 32'd1);
        checkOutput("hold_data", 32'(bus_a.o_data), 32'(prev_data));
      end
      if (bus_a.o_valid && o_ready) begin
        checkOutput("out_pending", 32'(exp_x.size() > 0), 32'd1);
        if (exp_x.size() > 0) begin
          x   = exp_x.pop_front();
          lat = cyc + 1 - exp_cyc.pop_front();
          e = refQuant(x, RM[0], OM[0], ovf);
          checkOutput("a_data", 32'(bus_a.o_data), 32'(e));
          e = refQuant(x, RM[1], OM[1], ovf);
          checkOutput("b_data", 32'(bus_b.o_data), 32'(e));
          e = refQuant(x, RM[2], OM[2], ovf);
          checkOutput("c_data", 32'(bus_c.o_data), 32'(e));
          log_a.push_back(int'(bus_a.o_data));
          log_b.push_back(int'(bus_b.o_data));
          log_c.push_back(int'(bus_c.o_data));
          if (strict_lat) checkOutput("latency", 32'(lat), 32'd2);
        end
      end
      if (i_valid && bus_a.i_ready) begin
        x = int'($signed(i_data));
        exp_x.push_back(x);
        exp_cyc.push_back(cyc + 1);
        for (int u = 0; u < 3; u++) begin
          void'(refQuant(x, RM[u], OM[u], ovf));
          if (ovf) begin
            sticky_m[u] = 1;
            if (cnt_m[u] < CMAX[u]) cnt_m[u]++;
          end
        end
      end
      prev_stall = bus_a.o_valid && !o_ready;
      prev_data  = bus_a.o_data;
    end
  end

  task automatic applyStimulus(input logic v, input logic [14:0] d, input logic rdy, input logic c);
    i_valid = v;
    i_data  = d;
    o_ready = rdy;
    clr     = c;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && exp_x.size() != 0; i++) applyStimulus(1'b0, 15'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 15'h0, 1'b1, 1'b0);
    checkOutput("drain_empty", 32'(exp_x.size()), 32'd0);
  endtask

  task automatic checkOvfModel(input string tag);
    checkOutput({tag, "_cnt_a"}, 32'(cnt_a), 32'(cnt_m[0]));
    checkOutput({tag, "_cnt_b"}, 32'(cnt_b), 32'(cnt_m[1]));
    checkOutput({tag, "_cnt_c"}, 32'(cnt_c), 32'(cnt_m[2]));
    checkOutput({tag, "_stk_a"}, 32'(sticky_a), 32'(sticky_m[0]));
    checkOutput({tag, "_stk_b"}, 32'(sticky_b), 32'(sticky_m[1]));
    checkOutput({tag, "_stk_c"}, 32'(sticky_c), 32'(sticky_m[2]));
  endtask

  task automatic clearOvf();
    applyStimulus(1'b0, 15'h0, 1'b1, 1'b1);
    clr = 1'b0;
    for (int u = 0; u < 3; u++) begin
      cnt_m[u]    = 0;
      sticky_m[u] = 0;
    end
    checkOvfModel("clear");
  endtask

  task automatic clearLogs();
    log_a.delete();
    log_b.delete();
    log_c.delete();
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int k, t;
    bit acc;
    bit pat [4];
    logic [14:0] d;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    rst = 1'b1; i_valid = 1'b0; i_data = '0; o_ready = 1'b0; clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_valid", 32'(bus_a.o_valid), 32'd0);
    checkOutput("rst_data", 32'(bus_a.o_data), 32'd0);
    checkOutput("rst_cnt", 32'(cnt_a), 32'd0);
    checkOutput("rst_sticky", 32'(sticky_a), 32'd0);
    rst = 1'b0;

    $display("[TB] rounding modes");
    clearLogs();
    strict_lat = 1'b1;
    applyStimulus(1'b1, 15'h0018, 1'b1, 1'b0);
    applyStimulus(1'b1, 15'h0028, 1'b1, 1'b0);
    applyStimulus(1'b1, 15'h7FE8, 1'b1, 1'b0);
    drain();
    checkOutput("rnd_count", 32'(log_a.size()), 32'd3);
    checkOutput("rnd_a0", 32'(logAt(0, 0)), 32'h002);
    checkOutput("rnd_a1", 32'(logAt(0, 1)), 32'h003);
    checkOutput("rnd_a2", 32'(logAt(0, 2)), 32'h3FF);
    checkOutput("rnd_b0", 32'(logAt(1, 0)), 32'h002);
    checkOutput("rnd_b1", 32'(logAt(1, 1)), 32'h002);
    checkOutput("rnd_b2", 32'(logAt(1, 2)), 32'h3FE);
    checkOutput("rnd_c0", 32'(logAt(2, 0)), 32'h001);
    checkOutput("rnd_c1", 32'(logAt(2, 1)), 32'h002);
    checkOutput("rnd_c2", 32'(logAt(2, 2)), 32'h3FE);
    checkOutput("rnd_no_ovf", 32'(cnt_a), 32'd0);

    $display("[TB] saturation and wrap");
    clearLogs();
    applyStimulus(1'b1, 15'h3FFF, 1'b1, 1'b0);
    applyStimulus(1'b1, 15'h4000, 1'b1, 1'b0);
    applyStimulus(1'b1, 15'h1FF8, 1'b1, 1'b0);
    drain();
    checkOutput("sat_a0", 32'(logAt(0, 0)), 32'h1FF);
    checkOutput("sat_a1", 32'(logAt(0, 1)), 32'h200);
    checkOutput("sat_a2", 32'(logAt(0, 2)), 32'h1FF);
    checkOutput("wrap_c0", 32'(logAt(2, 0)), 32'h3FF);
    checkOutput("sat_cnt_a", 32'(cnt_a), 32'd3);
    checkOutput("sat_sticky_a", 32'(sticky_a), 32'd1);
    checkOvfModel("sat");
    strict_lat = 1'b0;

    $display("[TB] counter saturation and clear");
    clearOvf();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 15'h3FFF, 1'b1, 1'b0);
    drain();
    checkOutput("cnt_sat_b", 32'(cnt_b), 32'd3);
    checkOutput("cnt_a5", 32'(cnt_a), 32'd5);
    checkOvfModel("cnt5");
    applyStimulus(1'b1, 15'h3FFF, 1'b1, 1'b0);
    applyStimulus(1'b0, 15'h0, 1'b1, 1'b1);
    clr = 1'b0;
    checkOutput("clr_evt_valid", 32'(bus_a.o_valid), 32'd1);
    checkOutput("clr_evt_cnt_a", 32'(cnt_a), 32'd1);
    checkOutput("clr_evt_cnt_b", 32'(cnt_b), 32'd1);
    checkOutput("clr_evt_stk_b", 32'(sticky_b), 32'd1);
    for (int u = 0; u < 3; u++) begin
      cnt_m[u]    = 1;
      sticky_m[u] = 1;
    end
    drain();
    checkOvfModel("clr_evt");
    clearOvf();

    $display("[TB] backpressure ramp");
    clearLogs();
    k = 0;
    t = 0;
    while (k < 8 && t < 64) begin
      i_valid = 1'b1;
      i_data  = 15'(16 * k);
      o_ready = pat[t % 4];
      clr     = 1'b0;
      @(negedge clk);
      acc = bus_a.i_ready;
      @(posedge clk);
      #1;
      if (acc) k++;
      t++;
    end
    checkOutput("bp_accepted", 32'(k), 32'd8);
    drain();
    checkOutput("bp_count", 32'(log_a.size()), 32'd8);
    for (int j = 0; j < 8; j++) checkOutput("bp_order", 32'(logAt(0, j)), 32'(j));

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      d = 15'($urandom_range(0, 32767));
      case ($urandom_range(0, 7))
        0: d = 15'h3FFF;
        1: d = 15'h4000;
        2: d = 15'(16 * $urandom_range(0, 2047) + 8);
        default: ;
      endcase
      applyStimulus($urandom_range(0, 3) != 0, d, $urandom_range(0, 3) != 0, 1'b0);
    end
    drain();
    checkOvfModel("rand");

    $display("[TB] reset mid-stream");
    applyStimulus(1'b1, 15'h3FFF, 1'b0, 1'b0);
    applyStimulus(1'b1, 15'h4000, 1'b0, 1'b0);
    i_valid = 1'b0;
    #1;
    checkOutput("full_iready", 32'(bus_a.i_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("mid_rst_valid", 32'(bus_a.o_valid), 32'd0);
    checkOutput("mid_rst_cnt", 32'(cnt_a), 32'd0);
    checkOutput("mid_rst_sticky", 32'(sticky_a), 32'd0);
    clearLogs();
    strict_lat = 1'b1;
    applyStimulus(1'b1, 15'h0028, 1'b1, 1'b0);
    drain();
    checkOutput("post_rst_count", 32'(log_a.size()), 32'd1);
    checkOutput("post_rst_data", 32'(logAt(0, 0)), 32'h003);
    checkOvfModel("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
